clk_div_int: RTL and testbench

// - Programmable integer clock divider: derives o_div_clk = i_ref_clk / i_div_ratio.
// - Feeds slower-domain logic (e.g. UART baud clocks) from one reference clock.
// - Passes the reference clock straight through when disabled or when the ratio cannot divide (0 or 1).

---
 rtl/clk_div_pkg.sv | 25 ++
 rtl/clk_div_cnt.sv | 68 ++++++
 rtl/clk_div_int.sv | 108 ++++++++++
 tb/tb_clk_div_int.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared types and helpers for the integer clock divider.
//               Holds the default ratio width, the ratio and counter types,
//               and the half-ratio helper used by the divider counter.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Default width of the division ratio input.
    localparam int RATIO_WD_DEF = 8;

    // Ratio word and counter word at the default width. The counter only
    // needs to reach N>>1, so it is one bit narrower than the ratio.
    typedef logic [RATIO_WD_DEF-1:0] ratio_t;
    typedef logic [RATIO_WD_DEF-2:0] cnt_t;

    // Length of the short phase of a period (floor(N/2)).
    function automatic cnt_t half_of(input ratio_t ratio);
        half_of = cnt_t'(ratio >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_cnt.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_cnt
// Description : Phase counter and threshold compare for the clock divider.
//               Counts reference edges since the last toggle of the divided
//               clock and pulses o_toggle on the edge that ends a phase.
//
// Ports       : i_ref_clk     - reference clock, rising edge
//               i_rst         - synchronous active-high reset
//               i_act         - divider active; counter held at 0 otherwise
//               i_ratio       - effective division ratio N
//               i_short_phase - the short phase of an odd ratio is running
//               o_toggle      - end of the current phase (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_cnt
    import clk_div_pkg::*;
#(
    parameter int RATIO_WD = RATIO_WD_DEF
) (
    input  logic                i_ref_clk,
    input  logic                i_rst,
    input  logic                i_act,
    input  logic [RATIO_WD-1:0] i_ratio,
    input  logic                i_short_phase,
    output logic                o_toggle
);

    localparam logic [RATIO_WD-2:0] c_cnt_one = {{(RATIO_WD-2){1'b0}}, 1'b1};

    logic [RATIO_WD-2:0] w_half;
    logic [RATIO_WD-2:0] w_thresh;
    logic                w_long_phase;
    logic [RATIO_WD-2:0] r_cnt;

    // At the package width the shared helper computes the half ratio; any
    // other width falls back to a plain slice.
    generate
        if (RATIO_WD == RATIO_WD_DEF) begin : g_half_pkg
            assign w_half = half_of(i_ratio);
        end else begin : g_half_slice
            assign w_half = i_ratio[RATIO_WD-1:1];
        end
    endgenerate

    // An odd ratio gets one extra reference cycle in the phase that is not
    // marked short (the low phase). Even ratios always use half-1, which
    // yields N/2 edges per phase because the count starts at 0.
    assign w_long_phase = i_ratio[0] && !i_short_phase;
    assign w_thresh     = w_long_phase ? w_half : (w_half - c_cnt_one);

    // Greater-or-equal rather than equality: if the ratio shrinks below the
    // current count mid-phase, the very next edge ends the phase instead of
    // letting the counter run on and wrap.
    assign o_toggle = i_act && (r_cnt >= w_thresh);

    always_ff @(posedge i_ref_clk) begin
        if (i_rst || !i_act) begin
            r_cnt <= '0;
        end else if (o_toggle) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clk_div_int.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_int
// Description : Programmable integer clock divider. o_div_clk is the
//               reference clock divided by i_div_ratio when enabled and the
//               ratio is at least 2; otherwise the reference clock is passed
//               straight through. Each divided period starts with its low
//               phase; odd ratios run the low phase one cycle longer.
//
// Ports       : i_ref_clk   - reference clock, all flops on its rising edge
//               i_rst       - synchronous active-high reset
//               i_clk_en    - 1 = divide, 0 = bypass
//               i_div_ratio - division ratio N (unsigned)
//               o_div_clk   - divided clock, or i_ref_clk in bypass
//
// Build macro : CLKDIV_RATIO_LATCH_EN - when defined, i_clk_en and
//               i_div_ratio are captured into shadow registers at reset, on
//               each rising toggle of the divided clock, and continuously
//               while the shadows describe bypass. Ratio changes then only
//               take effect on whole-period boundaries. When undefined the
//               inputs are used live.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_int
    import clk_div_pkg::*;
#(
    parameter int RATIO_WD = RATIO_WD_DEF
) (
    input  logic                i_ref_clk,
    input  logic                i_rst,
    input  logic                i_clk_en,
    input  logic [RATIO_WD-1:0] i_div_ratio,
    output logic                o_div_clk
);

    localparam logic [RATIO_WD-1:0] c_ratio_one = {{(RATIO_WD-1){1'b0}}, 1'b1};

    logic                w_en_eff;
    logic [RATIO_WD-1:0] w_ratio_eff;
    logic                w_div_act;
    logic                w_toggle;
    logic                w_rise;

    logic                r_div_q;
    // Set while the high (short) phase of an odd ratio is running.
    logic                r_odd_flag;

`ifdef CLKDIV_RATIO_LATCH_EN
    logic                r_en_sh;
    logic [RATIO_WD-1:0] r_ratio_sh;
    logic                w_sh_act;
    logic                w_sh_load;

    // While the shadows say "bypass" the live inputs are used directly and
    // reloaded every edge, so leaving bypass starts counting on the same
    // edge as in the live build. Once dividing, only a rising toggle of the
    // divided clock (the period boundary) or reset refreshes them.
    assign w_sh_act    = r_en_sh && (r_ratio_sh > c_ratio_one);
    assign w_en_eff    = w_sh_act ? r_en_sh    : i_clk_en;
    assign w_ratio_eff = w_sh_act ? r_ratio_sh : i_div_ratio;
    assign w_sh_load   = i_rst || !w_sh_act || w_rise;

    always_ff @(posedge i_ref_clk) begin
        if (w_sh_load) begin
            r_en_sh    <= i_clk_en;
            r_ratio_sh <= i_div_ratio;
        end
    end
`else
    assign w_en_eff    = i_clk_en;
    assign w_ratio_eff = i_div_ratio;
`endif

    assign w_div_act = w_en_eff && (w_ratio_eff > c_ratio_one);

    clk_div_cnt #(
        .RATIO_WD      (RATIO_WD)
    ) u_cnt (
        .i_ref_clk     (i_ref_clk),
        .i_rst         (i_rst),
        .i_act         (w_div_act),
        .i_ratio       (w_ratio_eff),
        .i_short_phase (r_odd_flag),
        .o_toggle      (w_toggle)
    );

    // A toggle while low ends the low phase: the divided clock rises here.
    assign w_rise = w_toggle && !r_div_q;

    // On the rising toggle the high phase begins; for an odd ratio it is the
    // short one. The parity comes from i_div_ratio because that is the value
    // in force for the coming phase (it is also what the shadows capture on
    // this edge).
    always_ff @(posedge i_ref_clk) begin
        if (i_rst || !w_div_act) begin
            r_div_q    <= 1'b0;
            r_odd_flag <= 1'b0;
        end else if (w_toggle) begin
            r_div_q    <= !r_div_q;
            r_odd_flag <= w_rise && i_div_ratio[0];
        end
    end

    // The only combinational path to the output is this bypass mux.
    assign o_div_clk = w_div_act ? r_div_q : i_ref_clk;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_int.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_int
// Description : Self-checking bench for clk_div_int. Reference model: after a
//               clean start with ratio N, the divided clock after k edges is
//               high when (k mod N) >= N - floor(N/2); in bypass it equals
//               the reference clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_int;
    import clk_div_pkg::*;

    localparam int RW = RATIO_WD_DEF;

    typedef struct {
        logic en;
        int   n;
        logic bypass;
        int   exp_high;
        int   exp_low;
    } step_vec_t;

    logic   r_clk   = 1'b0;
    logic   r_rst   = 1'b0;
    logic   r_en    = 1'b0;
    ratio_t r_ratio = '0;
    logic   w_div_clk;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 r_clk = ~r_clk;

    clk_div_int #(
        .RATIO_WD    (RW)
    ) dut (
        .i_ref_clk   (r_clk),
        .i_rst       (r_rst),
        .i_clk_en    (r_en),
        .i_div_ratio (r_ratio),
        .o_div_clk   (w_div_clk)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Divided-clock level k edges after a clean start (low phase first).
    function automatic logic ref_level(input int n, input int k);
        return ((k % n) >= (n - n / 2));
    endfunction

    // Reset with the given inputs, check the reset state, release, then
    // check len cycles on both clock phases against the model.
    task automatic run_seg(input logic e, input int n, input int len, input string tag);
        logic act;
        act = e && (n > 1);
        @(negedge r_clk);
        r_en    = e;
        r_ratio = ratio_t'(n);
        r_rst   = 1'b1;
        @(posedge r_clk); #1;
        check_bit($sformatf("%s_reset", tag), w_div_clk, act ? 1'b0 : 1'b1);
        @(negedge r_clk);
        r_rst = 1'b0;
        for (int k = 1; k <= len; k++) begin
            @(posedge r_clk); #1;
            check_bit($sformatf("%s_k%0d_hi", tag, k), w_div_clk, act ? ref_level(n, k) : 1'b1);
            @(negedge r_clk); #1;
            check_bit($sformatf("%s_k%0d_lo", tag, k), w_div_clk, act ? ref_level(n, k) : 1'b0);
        end
    endtask

    // Sample 35 cycles and extract one high and one low phase length.
    task automatic measure(output int hi, output int lo);
        logic s [0:34];
        int   r1, f1, r2;
        for (int i = 0; i < 35; i++) begin
            @(posedge r_clk); #1;
            s[i] = w_div_clk;
        end
        r1 = -1; f1 = -1; r2 = -1;
        for (int i = 1; i < 35; i++) begin
            if (r1 < 0) begin
                if (!s[i-1] && s[i]) r1 = i;
            end else if (f1 < 0) begin
                if (s[i-1] && !s[i]) f1 = i;
            end else if (r2 < 0) begin
                if (!s[i-1] && s[i]) r2 = i;
            end
        end
        hi = (r1 >= 0 && f1 >= 0) ? f1 - r1 : -1;
        lo = (f1 >= 0 && r2 >= 0) ? r2 - f1 : -1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        step_vec_t vecs [0:11];
        int        hi, lo, bad;
        logic      exp;

        vecs[0]  = '{1'b1,  1, 1'b1, 0, 0};
        vecs[1]  = '{1'b1,  2, 1'b0, 1, 1};
        vecs[2]  = '{1'b1,  3, 1'b0, 1, 2};
        vecs[3]  = '{1'b1,  4, 1'b0, 2, 2};
        vecs[4]  = '{1'b1,  5, 1'b0, 2, 3};
        vecs[5]  = '{1'b1,  6, 1'b0, 3, 3};
        vecs[6]  = '{1'b1,  7, 1'b0, 3, 4};
        vecs[7]  = '{1'b1,  8, 1'b0, 4, 4};
        vecs[8]  = '{1'b1,  9, 1'b0, 4, 5};
        vecs[9]  = '{1'b1, 10, 1'b0, 5, 5};
        vecs[10] = '{1'b1,  0, 1'b1, 0, 0};
        vecs[11] = '{1'b0, 10, 1'b1, 0, 0};

        // Reset state and first periods from a clean start.
        run_seg(1'b1, 4, 8, "rst_n4");
        run_seg(1'b1, 3, 6, "rst_n3");

        // Ratio stepped every 50 reference cycles without reset.
        for (int i = 0; i < 12; i++) begin
            @(negedge r_clk);
            r_en    = vecs[i].en;
            r_ratio = ratio_t'(vecs[i].n);
            repeat (15) @(posedge r_clk);
            if (vecs[i].bypass) begin
                bad = 0;
                for (int c = 0; c < 35; c++) begin
                    @(posedge r_clk); #1;
                    if (w_div_clk !== 1'b1) bad++;
                    @(negedge r_clk); #1;
                    if (w_div_clk !== 1'b0) bad++;
                end
                check_int($sformatf("step_en%0b_n%0d_bypass_errs", vecs[i].en, vecs[i].n), bad, 0);
            end else begin
                measure(hi, lo);
                check_int($sformatf("step_n%0d_high", vecs[i].n), hi, vecs[i].exp_high);
                check_int($sformatf("step_n%0d_low", vecs[i].n), lo, vecs[i].exp_low);
            end
        end

        // Reset mid-period at N=6 while the divided clock is high.
        run_seg(1'b1, 6, 4, "mid_pre");
        r_rst = 1'b1;
        @(posedge r_clk); #1;
        check_bit("mid_rst_q", w_div_clk, 1'b0);
        @(negedge r_clk);
        r_rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge r_clk); #1;
            check_bit($sformatf("mid_after_k%0d", k), w_div_clk, (k == 3) ? 1'b1 : 1'b0);
        end

        // Ratio 10 -> 2 while the counter sits at 4 in the high phase.
        run_seg(1'b1, 10, 9, "chg_pre");
        r_ratio = ratio_t'(2);
        for (int k = 10; k <= 22; k++) begin
            @(posedge r_clk); #1;
`ifdef CLKDIV_RATIO_LATCH_EN
            exp = (k <= 14) ? 1'b0 : logic'(k % 2);
`else
            exp = logic'(k % 2);
`endif
            check_bit($sformatf("chg_k%0d", k), w_div_clk, exp);
        end

`ifndef CLKDIV_RATIO_LATCH_EN
        // Enable 1 -> 0 -> 1 at N=4.
        run_seg(1'b1, 4, 6, "ena_pre");
        r_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge r_clk); #1;
            check_bit($sformatf("ena_byp%0d_hi", c), w_div_clk, 1'b1);
            @(negedge r_clk); #1;
            check_bit($sformatf("ena_byp%0d_lo", c), w_div_clk, 1'b0);
        end
        r_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge r_clk); #1;
            check_bit($sformatf("ena_re_k%0d", k), w_div_clk, ref_level(4, k));
        end
`endif

        // Randomized segments, each from a clean reset.
        for (int s = 0; s < 25; s++) begin
            int   n, len;
            logic e;
            e   = ($urandom_range(0, 9) != 0);
            n   = (s % 6 == 5) ? int'($urandom_range(17, 60)) : int'($urandom_range(0, 16));
            len = (n > 16) ? 2 * n + 5 : int'($urandom_range(8, 40));
            run_seg(e, n, len, $sformatf("rnd%0d_e%0b_n%0d", s, e, n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
